// File: rtl/router_register_if.sv
// Data/control bundle between the router FSM + input port (master) and the
// router register stage (slave).
interface router_register_if;
  logic       pkt_valid;
  logic [7:0] data_in;
  logic       fifo_full;
  logic       rst_int_reg;
  logic       detect_add;
  logic       lfd_state;
  logic       ld_state;
  logic       full_state;
  logic       laf_state;
  logic [7:0] dout;
  logic       parity_done;
  logic       low_pkt_valid;
  logic       err;

  modport master (
    output pkt_valid, data_in, fifo_full, rst_int_reg,
           detect_add, lfd_state, ld_state, full_state, laf_state,
    input  dout, parity_done, low_pkt_valid, err
  );

  modport slave (
    input  pkt_valid, data_in, fifo_full, rst_int_reg,
           detect_add, lfd_state, ld_state, full_state, laf_state,
    output dout, parity_done, low_pkt_valid, err
  );
endinterface

// File: rtl/router_register.sv
// Router data-path register: latches the header, stages bytes to the FIFOs,
// parks a byte while the FIFO is full and checks the packet's XOR parity.
module router_register (
  input  logic             clock,
  input  logic             resetn,
  router_register_if.slave bus
);

  logic [7:0] hdr;
  logic [7:0] full_byte;
  logic [7:0] int_parity;
  logic [7:0] pkt_parity;
  logic [7:0] dout;
  logic       parity_done;
  logic       low_pkt_valid;
  logic       err;

  logic hdr_load;
  logic parity_byte;
  logic set_parity_done;

  // Address 3 does not name a FIFO, so such a header is never latched.
  assign hdr_load    = bus.detect_add && bus.pkt_valid && (bus.data_in[1:0] != 2'b11);
  assign parity_byte = bus.ld_state && !bus.pkt_valid;

  // Parity is done either when the parity byte goes straight through, or when
  // it was parked during a full FIFO and is replayed in LOAD_AFTER_FULL.
  assign set_parity_done = (parity_byte && !bus.fifo_full) ||
                           (bus.laf_state && low_pkt_valid && !parity_done);

  // NOTE: state registers use non-blocking assignments so every register sees
  // the pre-edge value of its neighbours, and all of them clear on the
  // asynchronous reset rather than waiting for a clock edge.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      hdr <= '0;
    end else if (hdr_load) begin
      hdr <= bus.data_in;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      dout      <= '0;
      full_byte <= '0;
    end else if (bus.lfd_state) begin
      dout <= hdr;
    end else if (bus.ld_state && !bus.fifo_full) begin
      dout <= bus.data_in;
    end else if (bus.ld_state && bus.fifo_full) begin
      full_byte <= bus.data_in;
    end else if (bus.laf_state) begin
      dout <= full_byte;
    end
  end

  // The parked byte was already folded in during LOAD_DATA, so neither
  // FIFO_FULL_STATE nor its replay touches the running parity.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      int_parity <= '0;
    end else if (bus.detect_add) begin
      int_parity <= '0;
    end else if (bus.lfd_state) begin
      int_parity <= int_parity ^ hdr;
    end else if (bus.ld_state && bus.pkt_valid && !bus.full_state) begin
      int_parity <= int_parity ^ bus.data_in;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      pkt_parity <= '0;
    end else if (bus.detect_add) begin
      pkt_parity <= '0;
    end else if (parity_byte) begin
      pkt_parity <= bus.data_in;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      low_pkt_valid <= 1'b0;
    end else if (bus.rst_int_reg) begin
      low_pkt_valid <= 1'b0;
    end else if (parity_byte) begin
      low_pkt_valid <= 1'b1;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      parity_done <= 1'b0;
    end else if (bus.detect_add) begin
      parity_done <= 1'b0;
    end else if (set_parity_done) begin
      parity_done <= 1'b1;
    end
  end

  // err compares the registered parities, so it trails parity_done by a clock.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      err <= 1'b0;
    end else if (bus.detect_add) begin
      err <= 1'b0;
    end else if (parity_done) begin
      err <= (int_parity != pkt_parity);
    end
  end

  assign bus.dout          = dout;
  assign bus.parity_done   = parity_done;
  assign bus.low_pkt_valid = low_pkt_valid;
  assign bus.err           = err;

endmodule

// File: tb/tb_router_register.sv
// Directed bench for router_register: stimulus pushes hand-computed expected
// outputs into a queue, a negedge monitor pops and compares them.
module tb_router_register;

  localparam logic [7:0] C_DA  = 8'h01;
  localparam logic [7:0] C_LFD = 8'h02;
  localparam logic [7:0] C_LD  = 8'h04;
  localparam logic [7:0] C_FS  = 8'h08;
  localparam logic [7:0] C_LAF = 8'h10;
  localparam logic [7:0] C_RIR = 8'h20;
  localparam logic [7:0] C_PV  = 8'h40;
  localparam logic [7:0] C_FF  = 8'h80;

  typedef struct {
    string      name;
    logic [7:0] dout;
    logic       pd;
    logic       lpv;
    logic       err;
  } exp_t;

  logic clock;
  logic resetn;
  int   vectors     = 0;
  int   miscompares = 0;
  exp_t exp_q[$];

  router_register_if bus ();

  router_register dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic expect_out(input string name, input logic [7:0] xd,
                            input logic xp, input logic xl, input logic xe);
    exp_t e;
    e.name = name;
    e.dout = xd;
    e.pd   = xp;
    e.lpv  = xl;
    e.err  = xe;
    exp_q.push_back(e);
  endtask

  task automatic drive(input logic [7:0] ctl, input logic [7:0] d);
    bus.detect_add  = ctl[0];
    bus.lfd_state   = ctl[1];
    bus.ld_state    = ctl[2];
    bus.full_state  = ctl[3];
    bus.laf_state   = ctl[4];
    bus.rst_int_reg = ctl[5];
    bus.pkt_valid   = ctl[6];
    bus.fifo_full   = ctl[7];
    bus.data_in     = d;
  endtask

  // One clock of stimulus; the expectation describes outputs after this edge.
  task automatic step(input string name, input logic [7:0] ctl, input logic [7:0] d,
                      input logic [7:0] xd, input logic xp, input logic xl, input logic xe);
    @(negedge clock);
    #1;
    drive(ctl, d);
    expect_out(name, xd, xp, xl, xe);
  endtask

  always @(negedge clock) begin
    while (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      vectors++;
      if (bus.dout !== e.dout || bus.parity_done !== e.pd ||
          bus.low_pkt_valid !== e.lpv || bus.err !== e.err) begin
        miscompares++;
        $display("FAIL %s: got dout=%h parity_done=%b low_pkt_valid=%b err=%b, want dout=%h parity_done=%b low_pkt_valid=%b err=%b",
                 e.name, bus.dout, bus.parity_done, bus.low_pkt_valid, bus.err,
                 e.dout, e.pd, e.lpv, e.err);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    drive(8'h00, 8'h00);
    resetn = 1'b0;
    #1;
    expect_out("reset_initial", 8'h00, 1'b0, 1'b0, 1'b0);
    @(negedge clock);
    #2;
    resetn = 1'b1;

    // Good packet: header 16, payload 11..55, parity 07.
    step("good_hdr",    C_DA  | C_PV, 8'h16, 8'h00, 0, 0, 0);
    step("good_lfd",    C_LFD | C_PV, 8'h11, 8'h16, 0, 0, 0);
    step("good_p0",     C_LD  | C_PV, 8'h11, 8'h11, 0, 0, 0);
    step("good_p1",     C_LD  | C_PV, 8'h22, 8'h22, 0, 0, 0);
    step("good_p2",     C_LD  | C_PV, 8'h33, 8'h33, 0, 0, 0);
    step("good_p3",     C_LD  | C_PV, 8'h44, 8'h44, 0, 0, 0);
    step("good_p4",     C_LD  | C_PV, 8'h55, 8'h55, 0, 0, 0);
    step("good_parity", C_LD,         8'h07, 8'h07, 1, 1, 0);
    step("good_err",    8'h00,        8'h00, 8'h07, 1, 1, 0);
    step("good_rir",    C_RIR,        8'h00, 8'h07, 1, 0, 0);

    // Bad packet: same bytes, parity 2E.
    step("bad_hdr",     C_DA  | C_PV, 8'h16, 8'h07, 0, 0, 0);
    step("bad_lfd",     C_LFD | C_PV, 8'h11, 8'h16, 0, 0, 0);
    step("bad_p0",      C_LD  | C_PV, 8'h11, 8'h11, 0, 0, 0);
    step("bad_p1",      C_LD  | C_PV, 8'h22, 8'h22, 0, 0, 0);
    step("bad_p2",      C_LD  | C_PV, 8'h33, 8'h33, 0, 0, 0);
    step("bad_p3",      C_LD  | C_PV, 8'h44, 8'h44, 0, 0, 0);
    step("bad_p4",      C_LD  | C_PV, 8'h55, 8'h55, 0, 0, 0);
    step("bad_parity",  C_LD,         8'h2E, 8'h2E, 1, 1, 0);
    step("bad_err",     8'h00,        8'h00, 8'h2E, 1, 1, 1);
    step("bad_rir",     C_RIR,        8'h00, 8'h2E, 1, 0, 1);

    // Address 3 is ignored (header stays 16) and clears parity_done/err;
    // then a byte parked during full is replayed once and counted once.
    step("addr3_hdr",   C_DA  | C_PV,        8'h17, 8'h2E, 0, 0, 0);
    step("addr3_lfd",   C_LFD | C_PV,        8'h3C, 8'h16, 0, 0, 0);
    step("full_p0",     C_LD  | C_PV,        8'h3C, 8'h3C, 0, 0, 0);
    step("full_hold",   C_LD  | C_PV | C_FF, 8'hA5, 8'h3C, 0, 0, 0);
    step("full_state",  C_FS  | C_PV | C_FF, 8'h5A, 8'h3C, 0, 0, 0);
    step("full_laf",    C_LAF | C_PV,        8'h5A, 8'hA5, 0, 0, 0);
    step("full_parity", C_LD,                8'h8F, 8'h8F, 1, 1, 0);
    step("full_err",    8'h00,               8'h00, 8'h8F, 1, 1, 0);
    step("full_rir",    C_RIR,               8'h00, 8'h8F, 1, 0, 0);

    // Parity byte arrives while full: parity_done sets in LOAD_AFTER_FULL.
    step("laf_hdr",     C_DA  | C_PV,  8'h21, 8'h8F, 0, 0, 0);
    step("laf_lfd",     C_LFD | C_PV,  8'h0F, 8'h21, 0, 0, 0);
    step("laf_p0",      C_LD  | C_PV,  8'h0F, 8'h0F, 0, 0, 0);
    step("laf_par_full",C_LD  | C_FF,  8'h2E, 8'h0F, 0, 1, 0);
    step("laf_fstate",  C_FS  | C_FF,  8'h2E, 8'h0F, 0, 1, 0);
    step("laf_replay",  C_LAF,         8'h2E, 8'h2E, 1, 1, 0);
    step("laf_err",     8'h00,         8'h00, 8'h2E, 1, 1, 0);

    // detect_add together with ld_state: the clears win.
    step("da_ld",       C_DA | C_LD,   8'h99, 8'h99, 0, 1, 0);
    step("da_ld_idle",  8'h00,         8'h00, 8'h99, 0, 1, 0);
    step("pre_rst_par", C_LD,          8'h44, 8'h44, 1, 1, 0);
    step("pre_rst_err", 8'h00,         8'h00, 8'h44, 1, 1, 1);

    // Reset asserted between edges must clear outputs without a clock edge.
    @(negedge clock);
    #1;
    drive(8'h00, 8'h00);
    @(posedge clock);
    #1;
    resetn = 1'b0;
    expect_out("reset_mid", 8'h00, 1'b0, 1'b0, 1'b0);
    @(negedge clock);
    #2;
    resetn = 1'b1;

    step("post_rst_lfd", C_LFD,        8'h00, 8'h00, 0, 0, 0);
    step("post_rst_hdr", C_DA | C_PV,  8'h16, 8'h00, 0, 0, 0);
    step("post_rst_lfd2",C_LFD | C_PV, 8'h00, 8'h16, 0, 0, 0);

    @(negedge clock);
    #1;
    drive(8'h00, 8'h00);
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
